ifetch_unit: RTL and testbench
==============================

Name: ifetch_unit

Overview:
- Instruction fetch unit for the multi-cycle MIPS datapath.
- Owns the architectural PC register. The PC it holds is what the next-PC logic consumes, and the next-PC value it receives is what it commits.
- Issues word reads to instruction memory over a req/ack handshake and latches the returned word into the IR for the decoder.
- Buffers a PC update that arrives while a fetch is outstanding.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- npc  input  32  next-PC value from next-PC logic.
- pc_wr  input  1  commit npc into PC (from control).
- fetch  input  1  start a fetch at the current PC (from control).
- imem_req  output  1  instruction-memory read request.
- imem_addr  output  32  instruction-memory word address (byte address, [1:0]=0).
- imem_ack  input  1  memory returns data this cycle; sampled only while imem_req=1.
- imem_rdata  input  32  instruction word; valid when imem_ack=1.
- pc  output  32  architectural PC.
- ir  output  32  last fetched instruction.
- ir_pc  output  32  address ir was fetched from.
- ir_valid  output  1  ir holds a completed fetch.
- busy  output  1  fetch outstanding (state REQ).
- misalign  output  1  one-cycle pulse: fetch rejected because the address had [1:0]!=0.

Behaviour:
Reset (rst=1 at edge, from any state, including mid-fetch):
- pc=RESET_PC, ir=0, ir_pc=0, ir_valid=0, state=IDLE, imem_req=0, imem_addr=0, busy=0, misalign=0, pending flag cleared.
- An imem_ack in the reset cycle is ignored.

States: IDLE, REQ.

IDLE:
- Define eff_pc = npc if pc_wr else pc.
- pc_wr=1 → pc<=npc.
- fetch=1 and eff_pc[1:0]==0 → state<=REQ, imem_req<=1, imem_addr<=eff_pc, ir_pc<=eff_pc, ir_valid<=0.
- fetch=1 and eff_pc[1:0]!=0 → misalign<=1 for one cycle; no request; ir/ir_valid unchanged; state stays IDLE.
- When pc_wr and fetch are both asserted, the fetch uses the new PC.

REQ:
- imem_req=1 and imem_addr held stable until ack.
- fetch is ignored.
- pc_wr=1 → pend_npc<=npc, pend<=1. The last pc_wr before ack wins. pc does not change while in REQ.
- imem_ack=1 → ir<=imem_rdata, ir_valid<=1, imem_req<=0, state<=IDLE.
  - If pend=1 or pc_wr=1 in the ack cycle → pc<=(pc_wr ? npc : pend_npc), pend<=0.

Latency:
- fetch sampled at edge N → imem_req high from cycle N+1.
- Ack in cycle N+1 → ir_valid=1 from cycle N+2.
- Minimum 2 cycles fetch-to-valid; each wait cycle adds one.
- Back-to-back fetches: a new fetch may be accepted in the first IDLE cycle after ack.

Output and width rules:
- busy = (state==REQ).
- ir_valid stays 1 until the next accepted fetch or reset; pc_wr does not clear it.
- misalign is registered, high exactly one cycle per rejected fetch.
- No arithmetic here; PC+4 and branch targets come in on npc. pc is always whatever was last committed, not masked.

Test Plan:
- Reset: rst=1 two cycles → pc=32'h0000_3000, ir_valid=0, imem_req=0, busy=0; ack pulsed during reset → ir stays 0.
- Zero-wait fetch:
  - stimulus: fetch=1 one cycle; memory acks the first req cycle with 32'h2008_0005.
  - response: imem_addr=32'h3000 while req; ir=32'h2008_0005, ir_pc=32'h3000, ir_valid=1 two cycles after fetch.
- 3-wait fetch with pending PC update:
  - stimulus: fetch at pc=32'h3004; pc_wr with npc=32'h3008 during wait 1, then npc=32'h3010 during wait 2; ack at wait 3.
  - response: imem_addr held 32'h3004 throughout; pc stays 32'h3004 until ack, then pc=32'h3010; ir_pc=32'h3004.
- Simultaneous pc_wr+fetch in IDLE:
  - stimulus: pc=32'h3000, npc=32'h0040_0000, pc_wr=1, fetch=1.
  - response: pc=32'h0040_0000, imem_addr=32'h0040_0000, ir_pc=32'h0040_0000.
- Misaligned:
  - stimulus: pc_wr with npc=32'h3002, then fetch.
  - response: misalign=1 exactly one cycle, imem_req never rises, ir/ir_valid unchanged.
- Reset mid-fetch:
  - stimulus: rst=1 in REQ with ack=1 in the same cycle.
  - response: next cycle state IDLE, imem_req=0, ir_valid=0, pc=32'h3000, ir not updated.

Source files
------------

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: owns the PC, issues imem word reads over req/ack,
// latches the returned word into the IR and buffers PC updates made mid-fetch.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc,
  input  logic        pc_wr,
  input  logic        fetch,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic        ir_valid,
  output logic        busy,
  output logic        misalign
);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t      state;
  logic        pend;
  logic [31:0] pend_npc;
  logic [31:0] eff_pc;
  logic        eff_ok;

  // PC a fetch issued this cycle would use: a same-cycle write wins.
  always_comb begin
    eff_pc = pc_wr ? npc : pc;
    eff_ok = (eff_pc[1:0] == 2'b00);
  end

  assign busy = (state == REQ);

  // Fetch sequencer with registered request, IR and PC state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      ir        <= 32'h0;
      ir_pc     <= 32'h0;
      ir_valid  <= 1'b0;
      imem_req  <= 1'b0;
      imem_addr <= 32'h0;
      misalign  <= 1'b0;
      pend      <= 1'b0;
      pend_npc  <= 32'h0;
    end else begin
      misalign <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pc_wr) begin
            pc <= npc;
          end
          if (fetch && eff_ok) begin
            state     <= REQ;
            imem_req  <= 1'b1;
            imem_addr <= eff_pc;
            ir_pc     <= eff_pc;
            ir_valid  <= 1'b0;
          end else if (fetch) begin
            misalign <= 1'b1;
          end
        end
        REQ: begin
          if (imem_ack) begin
            state    <= IDLE;
            imem_req <= 1'b0;
            ir       <= imem_rdata;
            ir_valid <= 1'b1;
            if (pc_wr || pend) begin
              pc   <= pc_wr ? npc : pend_npc;
              pend <= 1'b0;
            end
          end else if (pc_wr) begin
            pend_npc <= npc;
            pend     <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: reset, fetch latency, pending PC,
// simultaneous write+fetch, misalign and reset during a fetch.
module tb_ifetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] npc;
  logic        pc_wr;
  logic        fetch;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        ir_valid;
  logic        busy;
  logic        misalign;

  int checks;
  int errors;

  ifetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .npc        (npc),
    .pc_wr      (pc_wr),
    .fetch      (fetch),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .pc         (pc),
    .ir         (ir),
    .ir_pc      (ir_pc),
    .ir_valid   (ir_valid),
    .busy       (busy),
    .misalign   (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pc_wr    = 1'b0;
    fetch    = 1'b0;
    imem_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    step();
    step();
    imem_ack = 1'b0;
    checks++;
    if (pc !== 32'h0000_3000) begin
      errors++;
      $display("FAIL reset_pc got %h want %h", pc, 32'h0000_3000);
    end
    checks++;
    if ({ir_valid, imem_req, busy, misalign} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000",
               {ir_valid, imem_req, busy, misalign});
    end
    checks++;
    if (ir !== 32'h0 || imem_addr !== 32'h0 || ir_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_regs got ir=%h addr=%h irpc=%h want 0",
               ir, imem_addr, ir_pc);
    end
    rst = 1'b0;
  endtask

  task automatic test_zero_wait();
    fetch = 1'b1;
    step();
    fetch = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || busy !== 1'b1 || imem_addr !== 32'h3000) begin
      errors++;
      $display("FAIL zw_req got req=%b busy=%b addr=%h want 1 1 3000",
               imem_req, busy, imem_addr);
    end
    imem_ack   = 1'b1;
    imem_rdata = 32'h2008_0005;
    step();
    imem_ack = 1'b0;
    checks++;
    if (ir !== 32'h2008_0005 || ir_pc !== 32'h3000 || ir_valid !== 1'b1) begin
      errors++;
      $display("FAIL zw_ir got ir=%h irpc=%h v=%b want 20080005 3000 1",
               ir, ir_pc, ir_valid);
    end
    checks++;
    if (imem_req !== 1'b0 || busy !== 1'b0 || pc !== 32'h3000) begin
      errors++;
      $display("FAIL zw_done got req=%b busy=%b pc=%h want 0 0 3000",
               imem_req, busy, pc);
    end
  endtask

  task automatic test_pending_pc();
    pc_wr = 1'b1;
    npc   = 32'h3004;
    step();
    pc_wr = 1'b0;
    fetch = 1'b1;
    step();
    fetch = 1'b0;
    checks++;
    if (imem_addr !== 32'h3004 || ir_valid !== 1'b0) begin
      errors++;
      $display("FAIL pend_issue got addr=%h v=%b want 3004 0",
               imem_addr, ir_valid);
    end
    pc_wr = 1'b1;
    npc   = 32'h3008;
    step();
    npc   = 32'h3010;
    fetch = 1'b1;
    step();
    pc_wr = 1'b0;
    fetch = 1'b0;
    checks++;
    if (pc !== 32'h3004 || imem_addr !== 32'h3004 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL pend_wait got pc=%h addr=%h req=%b want 3004 3004 1",
               pc, imem_addr, imem_req);
    end
    imem_ack   = 1'b1;
    imem_rdata = 32'h8C01_0004;
    step();
    imem_ack = 1'b0;
    checks++;
    if (pc !== 32'h3010 || ir_pc !== 32'h3004 || ir !== 32'h8C01_0004) begin
      errors++;
      $display("FAIL pend_ack got pc=%h irpc=%h ir=%h want 3010 3004 8c010004",
               pc, ir_pc, ir);
    end
    step();
    checks++;
    if (pc !== 32'h3010 || busy !== 1'b0 || ir_valid !== 1'b1) begin
      errors++;
      $display("FAIL pend_hold got pc=%h busy=%b v=%b want 3010 0 1",
               pc, busy, ir_valid);
    end
  endtask

  task automatic test_wr_and_fetch();
    pc_wr = 1'b1;
    npc   = 32'h3000;
    step();
    npc   = 32'h0040_0000;
    fetch = 1'b1;
    step();
    idle_inputs();
    checks++;
    if (pc !== 32'h0040_0000 || imem_addr !== 32'h0040_0000 ||
        ir_pc !== 32'h0040_0000) begin
      errors++;
      $display("FAIL wf got pc=%h addr=%h irpc=%h want 00400000 x3",
               pc, imem_addr, ir_pc);
    end
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_000C;
    step();
    imem_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    pc_wr = 1'b1;
    npc   = 32'h0040_0004;
    fetch = 1'b1;
    step();
    idle_inputs();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0004 ||
        ir_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_issue got req=%b addr=%h v=%b want 1 00400004 0",
               imem_req, imem_addr, ir_valid);
    end
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    step();
    imem_ack = 1'b0;
    checks++;
    if (ir !== 32'h1234_5678 || ir_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ir got ir=%h v=%b want 12345678 1", ir, ir_valid);
    end
  endtask

  task automatic test_misalign();
    pc_wr = 1'b1;
    npc   = 32'h3002;
    step();
    pc_wr = 1'b0;
    checks++;
    if (pc !== 32'h3002 || ir_valid !== 1'b1) begin
      errors++;
      $display("FAIL mis_pc got pc=%h v=%b want 3002 1", pc, ir_valid);
    end
    fetch = 1'b1;
    step();
    fetch = 1'b0;
    checks++;
    if (misalign !== 1'b1 || imem_req !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mis_pulse got mis=%b req=%b busy=%b want 1 0 0",
               misalign, imem_req, busy);
    end
    checks++;
    if (ir !== 32'h1234_5678 || ir_valid !== 1'b1) begin
      errors++;
      $display("FAIL mis_ir got ir=%h v=%b want 12345678 1", ir, ir_valid);
    end
    step();
    checks++;
    if (misalign !== 1'b0 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL mis_clear got mis=%b req=%b want 0 0",
               misalign, imem_req);
    end
  endtask

  task automatic test_reset_mid_fetch();
    pc_wr = 1'b1;
    npc   = 32'h3008;
    fetch = 1'b1;
    step();
    idle_inputs();
    checks++;
    if (busy !== 1'b1 || imem_addr !== 32'h3008) begin
      errors++;
      $display("FAIL rmf_issue got busy=%b addr=%h want 1 3008",
               busy, imem_addr);
    end
    rst        = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    rst      = 1'b0;
    imem_ack = 1'b0;
    checks++;
    if (busy !== 1'b0 || imem_req !== 1'b0 || ir_valid !== 1'b0 ||
        pc !== 32'h3000) begin
      errors++;
      $display("FAIL rmf_state got busy=%b req=%b v=%b pc=%h want 0 0 0 3000",
               busy, imem_req, ir_valid, pc);
    end
    checks++;
    if (ir !== 32'h0) begin
      errors++;
      $display("FAIL rmf_ir got %h want 00000000", ir);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    npc        = 32'h0;
    imem_rdata = 32'h0;
    idle_inputs();
    test_reset();
    test_zero_wait();
    test_pending_pc();
    test_wr_and_fetch();
    test_back_to_back();
    test_misalign();
    test_reset_mid_fetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
